// File: rtl/modulo_reservatorio_rolhas.sv
// Main cork reservoir: receives transfers over a 4-phase req/ack handshake, tracks stock, flags low/empty/full.
// Optional macro ROLHAS_BCD_EN adds registered BCD outputs reg_rd (tens) / reg_ru (units).
module modulo_reservatorio_rolhas #(
  parameter int unsigned WIDTH      = 7,
  parameter int unsigned CAPACIDADE = 99,
  parameter int unsigned MIN_ROLHAS = 5
) (
  input  logic             clk,
  input  logic             Nclr,
  input  logic             req_transf,
  input  logic [WIDTH-1:0] qtd_transf,
  output logic             ack_transf,
  output logic [WIDTH-1:0] qtd_aceita,
  input  logic             consumir,
  output logic [WIDTH-1:0] reg_r,
  output logic             ro,
  output logic             min_signal,
  output logic             cheio,
  output logic             erro_consumo
`ifdef ROLHAS_BCD_EN
  ,
  output logic [3:0]       reg_rd,
  output logic [3:0]       reg_ru
`endif
);

  localparam int unsigned    WS    = WIDTH + 1;
  localparam logic [WIDTH-1:0] CAP_W = WIDTH'(CAPACIDADE);
  localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_ROLHAS);

  typedef enum logic [1:0] {
    OCIOSO     = 2'b00,
    CARREGANDO = 2'b01,
    CONFIRMA   = 2'b10
  } estado_e;

  estado_e          state_q, state_d;
  logic [WIDTH-1:0] reg_r_q, reg_r_d;
  logic [WIDTH-1:0] restante_q, restante_d;
  logic [WIDTH-1:0] qtd_aceita_q, qtd_aceita_d;
  logic             ack_q, ack_d;
  logic             erro_q, erro_d;

  logic [WIDTH-1:0] vaga;
  logic [WIDTH-1:0] n_adm;
  logic             add;
  logic [WS-1:0]    soma;

  // State and datapath registers
  always_ff @(posedge clk or negedge Nclr) begin
    if (!Nclr) begin
      state_q      <= OCIOSO;
      reg_r_q      <= '0;
      restante_q   <= '0;
      qtd_aceita_q <= '0;
      ack_q        <= 1'b0;
      erro_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      reg_r_q      <= reg_r_d;
      restante_q   <= restante_d;
      qtd_aceita_q <= qtd_aceita_d;
      ack_q        <= ack_d;
      erro_q       <= erro_d;
    end
  end

  // Next state, stock update and handshake outputs
  always_comb begin
    state_d      = state_q;
    restante_d   = restante_q;
    qtd_aceita_d = qtd_aceita_q;
    reg_r_d      = reg_r_q;
    erro_d       = 1'b0;

    vaga  = CAP_W - reg_r_q;
    n_adm = (qtd_transf < vaga) ? qtd_transf : vaga;
    add   = (state_q == CARREGANDO);
    soma  = {1'b0, reg_r_q} + WS'(add);

    // Consumption with nothing in stock leaves stock untouched and flags the error
    if (soma >= WS'(consumir)) begin
      reg_r_d = WIDTH'(soma - WS'(consumir));
    end else begin
      erro_d = 1'b1;
    end

    case (state_q)
      OCIOSO: begin
        if (req_transf) begin
          restante_d   = n_adm;
          qtd_aceita_d = n_adm;
          state_d      = (n_adm != '0) ? CARREGANDO : CONFIRMA;
        end
      end
      CARREGANDO: begin
        restante_d = restante_q - WIDTH'(1);
        if (restante_q <= WIDTH'(1)) begin
          state_d = CONFIRMA;
        end
      end
      CONFIRMA: begin
        if (!req_transf) begin
          state_d = OCIOSO;
        end
      end
      default: state_d = OCIOSO;
    endcase

    ack_d = (state_d == CONFIRMA);
  end

  assign ack_transf   = ack_q;
  assign qtd_aceita   = qtd_aceita_q;
  assign reg_r        = reg_r_q;
  assign erro_consumo = erro_q;
  assign ro           = (reg_r_q == '0);
  assign min_signal   = (reg_r_q <= MIN_W);
  assign cheio        = (reg_r_q == CAP_W);

`ifdef ROLHAS_BCD_EN
  localparam logic [WIDTH-1:0] DEZ = WIDTH'(10);

  logic [3:0] reg_rd_q, reg_ru_q;

  // Display digits, one cycle behind the stock register
  always_ff @(posedge clk or negedge Nclr) begin
    if (!Nclr) begin
      reg_rd_q <= 4'd0;
      reg_ru_q <= 4'd0;
    end else begin
      reg_rd_q <= 4'(reg_r_q / DEZ);
      reg_ru_q <= 4'(reg_r_q % DEZ);
    end
  end

  assign reg_rd = reg_rd_q;
  assign reg_ru = reg_ru_q;
`endif

endmodule

// File: tb/tb_modulo_reservatorio_rolhas.sv
// Scoreboard bench for the cork reservoir: stimulus pushes expected ack/error events, a monitor pops and compares.
module tb_modulo_reservatorio_rolhas;

  localparam int unsigned WIDTH = 7;
  localparam int          TMO   = 300;

  logic             clk = 1'b0;
  logic             Nclr;
  logic             req_transf;
  logic [WIDTH-1:0] qtd_transf;
  logic             ack_transf;
  logic [WIDTH-1:0] qtd_aceita;
  logic             consumir;
  logic [WIDTH-1:0] reg_r;
  logic             ro, min_signal, cheio, erro_consumo;
`ifdef ROLHAS_BCD_EN
  logic [3:0]       reg_rd, reg_ru;
`endif

  modulo_reservatorio_rolhas #(.WIDTH(WIDTH), .CAPACIDADE(99), .MIN_ROLHAS(5)) dut (
    .clk          (clk),
    .Nclr         (Nclr),
    .req_transf   (req_transf),
    .qtd_transf   (qtd_transf),
    .ack_transf   (ack_transf),
    .qtd_aceita   (qtd_aceita),
    .consumir     (consumir),
    .reg_r        (reg_r),
    .ro           (ro),
    .min_signal   (min_signal),
    .cheio        (cheio),
    .erro_consumo (erro_consumo)
`ifdef ROLHAS_BCD_EN
    ,
    .reg_rd       (reg_rd),
    .reg_ru       (reg_ru)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int acc;
    int r;
    int full;
  } ack_exp_t;

  ack_exp_t ack_q[$];
  int       err_q[$];
  int       n_checks = 0;
  int       n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops an expectation on each ack rise and each error pulse
  logic ack_prev  = 1'b0;
  int   prev_r    = 0;
  logic nclr_prev = 1'b0;
  always @(negedge clk) begin
    if (Nclr) begin
      if (ack_transf && !ack_prev) begin
        if (ack_q.size() == 0) begin
          check("unexpected_ack", 1, 0);
        end else begin
          ack_exp_t e;
          e = ack_q.pop_front();
          check("ack_qtd_aceita", int'(qtd_aceita), e.acc);
          check("ack_reg_r", int'(reg_r), e.r);
          check("ack_cheio", int'(cheio), e.full);
        end
      end
      if (erro_consumo) begin
        if (err_q.size() == 0) begin
          check("unexpected_erro_consumo", 1, 0);
        end else begin
          check("erro_reg_r", int'(reg_r), err_q.pop_front());
        end
      end
`ifdef ROLHAS_BCD_EN
      if (nclr_prev) begin
        check("bcd_tens", int'(reg_rd), prev_r / 10);
        check("bcd_units", int'(reg_ru), prev_r % 10);
      end
`endif
    end
    ack_prev  = ack_transf;
    prev_r    = Nclr ? int'(reg_r) : 0;
    nclr_prev = Nclr;
  end

  task automatic push_ack(input int acc, input int r, input int full);
    ack_exp_t e;
    e.acc  = acc;
    e.r    = r;
    e.full = full;
    ack_q.push_back(e);
  endtask

  task automatic wait_ack(input logic level, output int cyc);
    cyc = 0;
    while (ack_transf !== level && cyc < TMO) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (ack_transf !== level) check("ack_timeout", int'(ack_transf), int'(level));
  endtask

  // Full well-behaved transfer; latency from request to ack is accepted+1 edges
  task automatic do_transfer(input int qtd, input int acc, input int r, input int full);
    int cyc;
    push_ack(acc, r, full);
    req_transf = 1'b1;
    qtd_transf = WIDTH'(qtd);
    @(posedge clk);
    #1;
    wait_ack(1'b1, cyc);
    check("ack_latency", cyc + 1, acc + 1);
    req_transf = 1'b0;
    @(posedge clk);
    #1;
    check("ack_drop", int'(ack_transf), 0);
  endtask

  task automatic consume(input int k);
    consumir = 1'b1;
    repeat (k) begin
      @(posedge clk);
      #1;
    end
    consumir = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_reg_r"}, int'(reg_r), 0);
    check({tag, "_ack"}, int'(ack_transf), 0);
    check({tag, "_qtd_aceita"}, int'(qtd_aceita), 0);
    check({tag, "_ro"}, int'(ro), 1);
    check({tag, "_min"}, int'(min_signal), 1);
    check({tag, "_cheio"}, int'(cheio), 0);
    check({tag, "_erro"}, int'(erro_consumo), 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    Nclr       = 1'b0;
    req_transf = 1'b0;
    qtd_transf = '0;
    consumir   = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk);
    #1;
    Nclr = 1'b1;

    // Loads: plain, partial to fill, then full reservoir admits nothing
    do_transfer(20, 20, 20, 0);
    check("min_after_20", int'(min_signal), 0);
    check("ro_after_20", int'(ro), 0);
    do_transfer(70, 70, 90, 0);
    do_transfer(20, 9, 99, 1);
    check("cheio_at_99", int'(cheio), 1);
    do_transfer(5, 0, 99, 1);

    // Drain down through the low-stock threshold to empty, then one extra
    consume(93);
    check("reg_after_93", int'(reg_r), 6);
    check("min_at_6", int'(min_signal), 0);
    consume(2);
    check("reg_at_4", int'(reg_r), 4);
    check("min_at_4", int'(min_signal), 1);
    consume(4);
    check("reg_at_0", int'(reg_r), 0);
    check("ro_at_0", int'(ro), 1);
    err_q.push_back(0);
    consume(1);
    check("reg_after_err", int'(reg_r), 0);
    @(posedge clk);
    #1;
    check("erro_single_cycle", int'(erro_consumo), 0);

    // Consumption overlapping a load from empty nets to zero without error
    push_ack(3, 0, 0);
    req_transf = 1'b1;
    qtd_transf = WIDTH'(3);
    @(posedge clk);
    #1;
    consumir = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    consumir = 1'b0;
    check("overlap_ack", int'(ack_transf), 1);
    check("overlap_reg", int'(reg_r), 0);
    req_transf = 1'b0;
    @(posedge clk);
    #1;
    check("overlap_ack_drop", int'(ack_transf), 0);

    // Request withdrawn mid-load: load completes, ack held for one cycle
    push_ack(4, 4, 0);
    req_transf = 1'b1;
    qtd_transf = WIDTH'(4);
    @(posedge clk);
    #1;
    req_transf = 1'b0;
    wait_ack(1'b1, cyc);
    check("violation_latency", cyc + 1, 5);
    wait_ack(1'b0, cyc);
    check("violation_ack_len", cyc, 1);
    check("violation_reg", int'(reg_r), 4);

    // Reset while loading on top of a stock of 12
    do_transfer(8, 8, 12, 0);
    req_transf = 1'b1;
    qtd_transf = WIDTH'(20);
    repeat (3) @(posedge clk);
    #2;
    check("pre_reset_reg", int'(reg_r), 14);
    Nclr = 1'b0;
    #1;
    check_reset_outputs("mid_load_reset");
    req_transf = 1'b0;
    @(posedge clk);
    #1;
    Nclr = 1'b1;
    do_transfer(2, 2, 2, 0);

    repeat (2) @(posedge clk);
    #1;
    check("ack_queue_empty", ack_q.size(), 0);
    check("err_queue_empty", err_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
